sel_encode_seq: RTL and testbench
=================================

# sel_encode_seq

Registered, parametrised select-and-encode unit for the datapath register file. It holds a local copy of the instruction register and decodes its Ra/Rb/Rc fields into one-hot register-file enables. It also extends the immediate field onto C. A built-in operand sequencer can drive a full three-register operation (Rb out, Rc out, Ra in) from one start pulse, so the control unit does not have to step it manually.

## Interface
Parameters:
- DATA_W, 32, instruction and C width
- REG_CNT, 16, number of registers; width of the one-hot enable buses
- FIELD_W, 4, register field width; must equal clog2(REG_CNT)
- RA_LSB, 23, LSB of the Ra field in the IR
- RB_LSB, 19, LSB of the Rb field
- RC_LSB, 15, LSB of the Rc field
- CONST_W, 15, immediate width, taken from IR bits [CONST_W-1:0]

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ir_load  in  1  capture ir_data into the internal IR (ir_q)
- ir_data  in  DATA_W  instruction word
- g_ra, g_rb, g_rc  in  1  manual field select; priority Ra > Rb > Rc
- r_in, r_out, ba_out  in  1  manual direction; r_in has priority over r_out/ba_out
- c_zext  in  1  1 = zero-extend the immediate, 0 = sign-extend it
- seq_start  in  1  start the auto sequence (one-cycle pulse)
- c  out  DATA_W  extended immediate
- rx_in  out  REG_CNT  one-hot register write enable
- rx_out  out  REG_CNT  one-hot register read enable
- sel_field  out  FIELD_W  last decoded register index
- seq_busy  out  1  sequencer active
- seq_done  out  1  one-cycle pulse when the sequence completes
- sel_err  out  1  one-cycle pulse when a command was rejected
- r0_zero  out  1  only when SEL_R0_ZERO_EN is defined; see Configuration

## Operation
- Reset: ir_q=0, c=0, rx_in=0, rx_out=0, sel_field=0, seq_busy=0, seq_done=0, sel_err=0, r0_zero=0. The FSM enters IDLE.
- C is combinational from ir_q: ir_q[CONST_W-1:0] sign-extended, or zero-extended when c_zext=1.
- FSM states:
  - IDLE: manual mode. seq_start moves to S_RB.
  - S_RB: drives rx_out from the Rb field. Always moves to S_RC.
  - S_RC: drives rx_out from the Rc field. Always moves to S_RA.
  - S_RA: drives rx_in from the Ra field. Always moves to DONE.
  - DONE: seq_done=1 for one cycle, then returns to IDLE.
- seq_busy is 1 in S_RB, S_RC and S_RA.
- Manual mode (IDLE only):
  - The selected field is decoded to one-hot.
  - If r_in is set, it drives rx_in. Otherwise, if r_out or ba_out is set, it drives rx_out.
  - No direction asserted: both one-hot buses are 0.
  - No g_* asserted: sel_field holds its previous value and both buses are 0.
- Outside IDLE, g_*, r_* and ba_out are ignored.
- rx_in and rx_out are never both nonzero in the same cycle.
- Rejected commands: ir_load or seq_start while seq_busy=1 is ignored, and sel_err pulses the following cycle. seq_start in DONE is also rejected.
- Manual commands and seq_start in the same IDLE cycle: seq_start wins. The manual command is dropped and does not set sel_err.

## Timing
- All outputs except c are registered. Inputs sampled at edge k take effect on the outputs after edge k, i.e. 1-cycle latency.
- ir_load together with a select in the same cycle: the select decodes the old ir_q. The new value is visible one cycle later.
- Sequence: seq_start sampled at edge k gives:
  - Rb out during cycle k+1
  - Rc out during cycle k+2
  - Ra in during cycle k+3
  - seq_done during cycle k+4
  - back-to-back restart accepted at k+5
- Reset asserted mid-sequence: all outputs clear immediately (asynchronously) and no seq_done is produced.

## Configuration
- SEL_R0_ZERO_EN defined:
  - When ba_out is the active direction and the decoded field is 0, rx_out stays 0 and r0_zero=1 for that cycle. R0 therefore reads as constant zero for base-address use.
  - r_out with field 0 still enables R0.
- SEL_R0_ZERO_EN undefined: the r0_zero port is absent, and ba_out behaves exactly like r_out.

## Test plan
- Reset then ir_load with ir_data=0x029CC001 (Ra=5, Rb=3, Rc=9):
  - c_zext=0 -> c=0xFFFFC001
  - c_zext=1 -> c=0x00004001
- Manual: g_rb=1, r_out=1 -> rx_out=0x0008 and sel_field=3 next cycle. Then g_ra=g_rb=1, r_in=r_out=1 -> rx_in=0x0020, rx_out=0.
- Sequence: pulse seq_start -> rx_out=0x0008, then 0x0200, then rx_in=0x0020, then seq_done=1. seq_busy is high for exactly 3 cycles.
- seq_start plus ir_load=1 (ir_data=0) during S_RC -> sel_err pulses, ir_q is unchanged, and the sequence finishes normally.
- IR with Rb=0, g_rb=1, ba_out=1:
  - macro defined -> rx_out=0, r0_zero=1
  - macro undefined -> rx_out=0x0001
- Drop rst_n in S_RC -> outputs are 0 immediately, seq_done never pulses, and a new seq_start after release runs a full sequence.

Source files
------------

// File: rtl/sel_encode_seq.sv
// rtl/sel_encode_seq.sv - IR field select/one-hot encode with 3-step operand sequencer
// Optional R0-as-zero for base-address reads: define SEL_R0_ZERO_EN.
module sel_encode_seq #(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 16,
  parameter int FIELD_W = 4,
  parameter int RA_LSB  = 23,
  parameter int RB_LSB  = 19,
  parameter int RC_LSB  = 15,
  parameter int CONST_W = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ir_load,
  input  logic [DATA_W-1:0]  ir_data,
  input  logic               g_ra,
  input  logic               g_rb,
  input  logic               g_rc,
  input  logic               r_in,
  input  logic               r_out,
  input  logic               ba_out,
  input  logic               c_zext,
  input  logic               seq_start,
  output logic [DATA_W-1:0]  c,
  output logic [REG_CNT-1:0] rx_in,
  output logic [REG_CNT-1:0] rx_out,
  output logic [FIELD_W-1:0] sel_field,
  output logic               seq_busy,
  output logic               seq_done,
  output logic               sel_err
`ifdef SEL_R0_ZERO_EN
  ,output logic              r0_zero
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] S_RB = 3'd1;
  localparam logic [2:0] S_RC = 3'd2;
  localparam logic [2:0] S_RA = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  logic [2:0]         state_q, state_d;
  logic [DATA_W-1:0]  ir_q, ir_d;
  logic [REG_CNT-1:0] rx_in_q, rx_in_d, rx_out_q, rx_out_d;
  logic [FIELD_W-1:0] sel_field_q, sel_field_d;
  logic               seq_busy_q, seq_busy_d;
  logic               seq_done_q, seq_done_d;
  logic               sel_err_q, sel_err_d;
  logic               r0_zero_d;
  logic [FIELD_W-1:0] ra_f, rb_f, rc_f, man_f;

  function automatic logic [REG_CNT-1:0] dec(input logic [FIELD_W-1:0] f);
    dec    = '0;
    dec[f] = 1'b1;
  endfunction

  assign ra_f  = ir_q[RA_LSB +: FIELD_W];
  assign rb_f  = ir_q[RB_LSB +: FIELD_W];
  assign rc_f  = ir_q[RC_LSB +: FIELD_W];
  assign man_f = g_ra ? ra_f : (g_rb ? rb_f : rc_f);

  assign c = {{(DATA_W-CONST_W){ir_q[CONST_W-1] & ~c_zext}}, ir_q[CONST_W-1:0]};

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    rx_in_d     = '0;
    rx_out_d    = '0;
    sel_field_d = sel_field_q;
    sel_err_d   = 1'b0;
    r0_zero_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ir_load) ir_d = ir_data;
        if (seq_start) begin
          state_d     = S_RB;
          rx_out_d    = dec(rb_f);
          sel_field_d = rb_f;
        end else if (g_ra || g_rb || g_rc) begin
          sel_field_d = man_f;
          if (r_in) begin
            rx_in_d = dec(man_f);
          end else if (r_out || ba_out) begin
            rx_out_d = dec(man_f);
`ifdef SEL_R0_ZERO_EN
            // Base-address reads of R0 yield constant zero instead of the register.
            if (ba_out && !r_out && man_f == '0) begin
              rx_out_d  = '0;
              r0_zero_d = 1'b1;
            end
`endif
          end
        end
      end
      S_RB: begin
        state_d     = S_RC;
        rx_out_d    = dec(rc_f);
        sel_field_d = rc_f;
        sel_err_d   = ir_load | seq_start;
      end
      S_RC: begin
        state_d     = S_RA;
        rx_in_d     = dec(ra_f);
        sel_field_d = ra_f;
        sel_err_d   = ir_load | seq_start;
      end
      S_RA: begin
        state_d   = DONE;
        sel_err_d = ir_load | seq_start;
      end
      DONE: begin
        state_d   = IDLE;
        if (ir_load) ir_d = ir_data;
        sel_err_d = seq_start;
      end
      default: state_d = IDLE;
    endcase
    // Flags are computed from the next state so they line up with the registered buses.
    seq_busy_d = (state_d == S_RB) || (state_d == S_RC) || (state_d == S_RA);
    seq_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ir_q        <= '0;
      rx_in_q     <= '0;
      rx_out_q    <= '0;
      sel_field_q <= '0;
      seq_busy_q  <= 1'b0;
      seq_done_q  <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      rx_in_q     <= rx_in_d;
      rx_out_q    <= rx_out_d;
      sel_field_q <= sel_field_d;
      seq_busy_q  <= seq_busy_d;
      seq_done_q  <= seq_done_d;
      sel_err_q   <= sel_err_d;
    end
  end

  assign rx_in     = rx_in_q;
  assign rx_out    = rx_out_q;
  assign sel_field = sel_field_q;
  assign seq_busy  = seq_busy_q;
  assign seq_done  = seq_done_q;
  assign sel_err   = sel_err_q;

`ifdef SEL_R0_ZERO_EN
  logic r0_zero_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r0_zero_q <= 1'b0;
    else        r0_zero_q <= r0_zero_d;
  end
  assign r0_zero = r0_zero_q;
`else
  logic unused_r0;
  assign unused_r0 = r0_zero_d;
`endif

endmodule

// File: tb/tb_sel_encode_seq.sv
// tb/tb_sel_encode_seq.sv - directed self-checking bench for sel_encode_seq
// Covers both builds of SEL_R0_ZERO_EN.
module tb_sel_encode_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_load;
  logic [31:0] ir_data;
  logic        g_ra, g_rb, g_rc, r_in, r_out, ba_out, c_zext, seq_start;
  logic [31:0] c;
  logic [15:0] rx_in, rx_out;
  logic [3:0]  sel_field;
  logic        seq_busy, seq_done, sel_err;
`ifdef SEL_R0_ZERO_EN
  logic        r0_zero;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic done_seen;

  always #5 clk = ~clk;

  sel_encode_seq dut (
    .clk(clk), .rst_n(rst_n), .ir_load(ir_load), .ir_data(ir_data),
    .g_ra(g_ra), .g_rb(g_rb), .g_rc(g_rc), .r_in(r_in), .r_out(r_out),
    .ba_out(ba_out), .c_zext(c_zext), .seq_start(seq_start), .c(c),
    .rx_in(rx_in), .rx_out(rx_out), .sel_field(sel_field),
    .seq_busy(seq_busy), .seq_done(seq_done), .sel_err(sel_err)
`ifdef SEL_R0_ZERO_EN
    , .r0_zero(r0_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir_load = 0; g_ra = 0; g_rb = 0; g_rc = 0;
    r_in = 0; r_out = 0; ba_out = 0; seq_start = 0;
  endtask

  initial begin
    idle_inputs();
    ir_data = 32'h0; c_zext = 0; rst_n = 0;
    #23;
    check("rst_c", c, 32'h0);
    check("rst_rx_in", {16'h0, rx_in}, 32'h0);
    check("rst_rx_out", {16'h0, rx_out}, 32'h0);
    check("rst_sel_field", {28'h0, sel_field}, 32'h0);
    check("rst_flags", {29'h0, seq_busy, seq_done, sel_err}, 32'h0);
    rst_n = 1;

    // Load IR: Ra=5, Rb=3, Rc=9, imm=0x4001
    ir_load = 1; ir_data = 32'h029CC001;
    step();
    ir_load = 0;
    check("c_sext", c, 32'hFFFFC001);
    c_zext = 1; #1;
    check("c_zext", c, 32'h00004001);
    c_zext = 0;

    g_rb = 1; r_out = 1;
    step();
    check("man_rb_out", {16'h0, rx_out}, 32'h0008);
    check("man_rb_field", {28'h0, sel_field}, 32'd3);
    check("man_rb_in0", {16'h0, rx_in}, 32'h0);
    g_ra = 1; r_in = 1;
    step();
    check("man_pri_in", {16'h0, rx_in}, 32'h0020);
    check("man_pri_out0", {16'h0, rx_out}, 32'h0);
    check("man_pri_field", {28'h0, sel_field}, 32'd5);
    idle_inputs();
    g_rc = 1;
    step();
    check("man_nodir", {rx_in, rx_out}, 32'h0);
    check("man_nodir_field", {28'h0, sel_field}, 32'd9);
    idle_inputs();
    step();
    check("man_nog_field", {28'h0, sel_field}, 32'd9);

    // Full sequence
    seq_start = 1;
    step();
    seq_start = 0;
    check("seq_rb", {16'h0, rx_out}, 32'h0008);
    check("seq_rb_busy", {31'h0, seq_busy}, 32'd1);
    step();
    check("seq_rc", {16'h0, rx_out}, 32'h0200);
    check("seq_rc_busy", {31'h0, seq_busy}, 32'd1);
    step();
    check("seq_ra", {rx_in, rx_out}, {16'h0020, 16'h0});
    check("seq_ra_busy", {31'h0, seq_busy}, 32'd1);
    step();
    check("seq_done", {30'h0, seq_busy, seq_done}, 32'b01);
    check("seq_done_bus", {rx_in, rx_out}, 32'h0);
    step();
    check("seq_idle", {30'h0, seq_busy, seq_done}, 32'b00);

    // Rejected commands during S_RC, then seq_start in DONE
    seq_start = 1;
    step();
    seq_start = 0;
    step();
    seq_start = 1; ir_load = 1; ir_data = 32'h0;
    step();
    idle_inputs();
    check("rej_err", {31'h0, sel_err}, 32'd1);
    check("rej_ra", {16'h0, rx_in}, 32'h0020);
    step();
    check("rej_done", {30'h0, seq_done, sel_err}, 32'b10);
    check("rej_ir_kept", c, 32'hFFFFC001);
    seq_start = 1;
    step();
    seq_start = 0;
    check("done_rej_err", {31'h0, sel_err}, 32'd1);
    check("done_rej_idle", {15'h0, seq_busy, rx_out}, 32'h0);

    // seq_start beats a simultaneous manual command
    seq_start = 1; g_ra = 1; r_in = 1;
    step();
    idle_inputs();
    check("start_wins", {rx_in, rx_out}, {16'h0, 16'h0008});
    check("start_wins_err", {31'h0, sel_err}, 32'd0);
    step(); step(); step(); step();

    // ir_load with select decodes the old IR; new IR: Ra=1, Rb=0, Rc=2
    ir_load = 1; ir_data = 32'h00810000; g_rb = 1; r_out = 1;
    step();
    ir_load = 0;
    check("old_ir_decode", {16'h0, rx_out}, 32'h0008);
    r_out = 0; ba_out = 1;
    step();
`ifdef SEL_R0_ZERO_EN
    check("ba_r0_out", {16'h0, rx_out}, 32'h0);
    check("ba_r0_flag", {31'h0, r0_zero}, 32'd1);
    ba_out = 0; r_out = 1;
    step();
    check("rout_r0", {16'h0, rx_out}, 32'h0001);
    check("rout_r0_flag", {31'h0, r0_zero}, 32'd0);
`else
    check("ba_r0_out", {16'h0, rx_out}, 32'h0001);
`endif
    idle_inputs();
    g_rc = 1; r_out = 1;
    step();
    idle_inputs();
    check("new_ir_rc", {16'h0, rx_out}, 32'h0004);
    check("new_ir_c", c, 32'h0);

    // Reset in S_RC
    seq_start = 1;
    step();
    seq_start = 0;
    step();
    check("pre_rst_rc", {16'h0, rx_out}, 32'h0004);
    #2 rst_n = 0;
    #1;
    check("mid_rst_bus", {rx_in, rx_out}, 32'h0);
    check("mid_rst_flags", {28'h0, seq_busy, seq_done, sel_err, 1'b0}, 32'h0);
    check("mid_rst_field", {28'h0, sel_field}, 32'h0);
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      done_seen = done_seen | seq_done;
    end
    #3 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      done_seen = done_seen | seq_done;
    end
    check("no_done_after_rst", {31'h0, done_seen}, 32'd0);
    seq_start = 1;
    step();
    seq_start = 0;
    check("post_rst_rb", {16'h0, rx_out}, 32'h0001);
    step();
    check("post_rst_rc", {16'h0, rx_out}, 32'h0001);
    step();
    check("post_rst_ra", {16'h0, rx_in}, 32'h0001);
    step();
    check("post_rst_done", {31'h0, seq_done}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
